// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multicycle memory responder.
// State encoding, operation encoding, word width and wait-state limit.
package mem_resp_pkg;

    localparam int WORD_W   = 32;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between the processor datapath and the memory.
// master: requester (mem_read, mem_write, addr, wdata); slave: the memory.
interface multicycle_mem_responder_if;
    import mem_resp_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              mem_ready;
    logic              busy;
    logic              err;
    logic [WORD_W-1:0] read_count;
    logic [WORD_W-1:0] write_count;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, busy, err,
        input  read_count, write_count
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, busy, err,
        output read_count, write_count
    );

endinterface

// File: rtl/mem_resp_array.sv
// Word storage: DEPTH_WORDS x 32, synchronous write, combinational read.
// Ports: clk, i_we, i_waddr, i_wdata, i_raddr -> o_rdata. Not reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/multicycle_mem_responder.sv
// Unified memory slave with WAIT_CYCLES wait states and mem_ready handshake.
// Ports: clk, rst (async active-low), bus (slave modport). Stats: MEM_STATS_EN.
module multicycle_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic                           clk,
    input logic                           rst,
    multicycle_mem_responder_if.slave     bus
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    state_t            r_state;
    op_t               r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_bad;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;
    logic [WORD_W-1:0] r_rdata;

    logic              w_req;
    logic              w_bad_in;
    logic [IDX_W-1:0]  w_idx_in;
    logic              w_bad;
    logic              w_rd;
    logic [IDX_W-1:0]  w_raddr;
    logic              w_go_done;
    logic              w_we;
    logic [WORD_W-1:0] w_arr_rdata;
    logic              w_unused_addr;

    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_bad_in = (bus.addr[1:0] != 2'b00)
                    | (bus.mem_read & bus.mem_write);
    assign w_idx_in = bus.addr[IDX_W+1:2];
    assign w_unused_addr = ^bus.addr[WORD_W-1:IDX_W+2];

    // With zero wait states DONE is entered straight from IDLE, so the
    // completion attributes come from the live inputs rather than latches.
    always_comb begin
        w_bad   = r_bad;
        w_rd    = (r_op == OP_RD);
        w_raddr = r_idx;
        if (r_state == IDLE) begin
            w_bad   = w_bad_in;
            w_rd    = ~bus.mem_write;
            w_raddr = w_idx_in;
        end
    end

    assign w_go_done = ((r_state == IDLE) && w_req && (WAIT_L == 4'd0))
                     | ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_we = (r_state == DONE) && (r_op == OP_WR) && !r_bad;

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_idx   <= '0;
            r_wdata <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_req) begin
                        r_op    <= bus.mem_write ? OP_WR : OP_RD;
                        r_idx   <= w_idx_in;
                        r_wdata <= bus.wdata;
                        r_bad   <= w_bad_in;
                        r_cnt   <= WAIT_L;
                        r_busy  <= 1'b1;
                        r_state <= (WAIT_L == 4'd0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // DONE-entry outputs; these later assignments take precedence.
            if (w_go_done) begin
                r_ready <= 1'b1;
                r_err   <= w_bad;
                if (w_bad) begin
                    r_rdata <= '0;
                end else if (w_rd) begin
                    r_rdata <= w_arr_rdata;
                end
            end
        end
    end

`ifdef MEM_STATS_EN
    logic [WORD_W-1:0] r_rd_cnt;
    logic [WORD_W-1:0] r_wr_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if ((r_state == DONE) && !r_bad) begin
            if (r_op == OP_RD) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end else begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    assign bus.read_count  = r_rd_cnt;
    assign bus.write_count = r_wr_cnt;
`else
    assign bus.read_count  = '0;
    assign bus.write_count = '0;
`endif

    assign bus.rdata     = r_rdata;
    assign bus.mem_ready = r_ready;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states), random + directed.
// Expected completions are queued at issue and checked by a monitor.
module tb_multicycle_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdq [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        erq [2];
    logic [31:0] rcq [2];
    logic [31:0] wcq [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gd
        multicycle_mem_responder_if mif ();
        assign mif.mem_read  = rd[g];
        assign mif.mem_write = wr[g];
        assign mif.addr      = ad[g];
        assign mif.wdata     = wd[g];
        assign rdq[g] = mif.rdata;
        assign rdy[g] = mif.mem_ready;
        assign bsy[g] = mif.busy;
        assign erq[g] = mif.err;
        assign rcq[g] = mif.read_count;
        assign wcq[g] = mif.write_count;
        multicycle_mem_responder #(
            .DEPTH_WORDS (256),
            .WAIT_CYCLES ((g == 0) ? 2 : 0)
        ) dut (
            .clk (clk),
            .rst (rst_n),
            .bus (mif.slave)
        );
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mdl [2][256];
    logic [31:0] last_rd [2];
    int unsigned rcnt [2];
    int unsigned wcnt [2];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Monitor: every completion pulse is matched with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   empty;
        for (int g = 0; g < 2; g++) begin
            if (rst_n && rdy[g]) begin
                empty = (g == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: got 1 expected 0",
                             g);
                end else begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("err dut%0d", g), 32'(erq[g]),
                          32'(e.err));
                    check($sformatf("rdata dut%0d", g), rdq[g], e.rdata);
                    check($sformatf("busy_at_ready dut%0d", g),
                          32'(bsy[g]), 32'd1);
                end
            end
        end
    end

    // Issue one request (left asserted on return, during the DONE cycle).
    task automatic issue(input int g, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   bad;
        int   idx;
        int   k;
        bad = (a % 4 != 0) || (r && w);
        idx = int'((a / 4) % 256);
        e.err = bad;
        if (bad) begin
            e.rdata = 32'h0;
            last_rd[g] = 32'h0;
        end else if (r) begin
            e.rdata = mdl[g][idx];
            last_rd[g] = e.rdata;
            rcnt[g]++;
        end else begin
            mdl[g][idx] = d;
            e.rdata = last_rd[g];
            wcnt[g]++;
        end
        if (g == 0) q0.push_back(e);
        else q1.push_back(e);
        rd[g] = r;
        wr[g] = w;
        ad[g] = a;
        wd[g] = d;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bsy[g] && k < 4);
        if (!bsy[g]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: got busy 0 expected 1", g);
        end
        k = 0;
        while (!rdy[g] && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check($sformatf("latency dut%0d", g), 32'(k),
              (g == 0) ? 32'd2 : 32'd0);
    endtask

    task automatic drop(input int g);
        rd[g] = 1'b0;
        wr[g] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int g);
        logic [31:0] er;
        logic [31:0] ew;
`ifdef MEM_STATS_EN
        er = rcnt[g];
        ew = wcnt[g];
`else
        er = 32'h0;
        ew = 32'h0;
`endif
        check($sformatf("read_count dut%0d", g), rcq[g], er);
        check($sformatf("write_count dut%0d", g), wcq[g], ew);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        else a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        time         t1;
        logic [31:0] v;
        int          kind;
        for (int g = 0; g < 2; g++) begin
            rd[g] = 1'b0;
            wr[g] = 1'b0;
            ad[g] = 32'h0;
            wd[g] = 32'h0;
            last_rd[g] = 32'h0;
            rcnt[g] = 0;
            wcnt[g] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_ready dut%0d", g), 32'(rdy[g]), 32'd0);
            check($sformatf("rst_busy dut%0d", g), 32'(bsy[g]), 32'd0);
            check($sformatf("rst_err dut%0d", g), 32'(erq[g]), 32'd0);
            check($sformatf("rst_rdata dut%0d", g), rdq[g], 32'd0);
            chk_cnt(g);
        end

        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        drop(0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drop(0);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 256; i++) begin
                issue(g, 1'b0, 1'b1, 32'(i * 4), $urandom);
            end
            drop(g);
        end

        issue(1, 1'b1, 1'b0, 32'h0, 32'h0);
        t1 = $time;
        issue(1, 1'b1, 1'b0, 32'h4, 32'h0);
        check("b2b_spacing", 32'(($time - t1) / 10), 32'd2);
        drop(1);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 60; i++) begin
                kind = $urandom_range(0, 9);
                issue(g, kind != 1 && kind < 5 ? 1'b0 : 1'b1,
                      kind < 5 ? 1'b1 : 1'b0, rnd_addr(), $urandom);
                if ($urandom_range(0, 1) == 1) begin
                    rd[g] = 1'b0;
                    wr[g] = 1'b0;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            drop(g);
            drop(g);
            chk_cnt(g);
        end

        issue(0, 1'b1, 1'b0, 32'h12, 32'h0);
        issue(0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        issue(0, 1'b1, 1'b0, 32'h8, 32'h0);
        drop(0);
        drop(0);
        chk_cnt(0);

        issue(0, 1'b0, 1'b1, 32'h400, 32'h5);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drop(0);

        v = $urandom;
        rd[0] = 1'b0;
        wr[0] = 1'b1;
        ad[0] = 32'h20;
        wd[0] = v;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy[0]), 32'd0);
        check("midrst_busy", 32'(bsy[0]), 32'd0);
        check("midrst_err", 32'(erq[0]), 32'd0);
        check("midrst_rdata", rdq[0], 32'd0);
        wr[0] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            last_rd[g] = 32'h0;
            rcnt[g] = 0;
            wcnt[g] = 0;
        end
        chk_cnt(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0);
        issue(0, 1'b0, 1'b1, 32'h24, 32'hA5A5_0001);
        issue(0, 1'b1, 1'b0, 32'h24, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0);
        issue(0, 1'b0, 1'b1, 32'h28, 32'h3);
        issue(0, 1'b1, 1'b0, 32'h2A, 32'h0);
        drop(0);
        drop(0);
        chk_cnt(0);

        repeat (4) @(posedge clk);
        check("pending_expectations", 32'(q0.size() + q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_mem_responder.md
# multicycle_mem_responder

- Unified instruction/data memory slave that answers the multicycle processor's memory requests: the `mem_read`/`mem_write` strobes plus address from the datapath's IorD mux.
- Adds programmable wait states and a `mem_ready` completion handshake, so the control FSM stalls in its memory states until the access completes.
- Flags misaligned word accesses instead of silently corrupting memory.

## Interface

- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, at least 4.
- WAIT_CYCLES, 2, wait states between request acceptance and completion; range 0–15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request; held by the requester until `mem_ready`.
- mem_write  input  1  write request; held by the requester until `mem_ready`.
- addr  input  32  byte address; bits [1:0] must be 0.
- wdata  input  32  write data.
- rdata  output  32  read data; valid in the `mem_ready` cycle of a read, held until the next read completes.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the cycle after `mem_ready`.
- err  output  1  qualifies `mem_ready`: the access was rejected.
- read_count  output  32  completed good reads (see Configuration).
- write_count  output  32  completed good writes (see Configuration).

## Operation

- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - `mem_read | mem_write` accepts the request.
  - On acceptance, latch op, addr, wdata; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else DONE.
- WAIT:
  - Counter decrements each cycle; the FSM moves to DONE when the counter reaches 1.
  - Input changes during WAIT are ignored; only the latched request is used.
- DONE:
  - `mem_ready` = 1 for this cycle only.
  - A good write commits to the array at the end of the cycle.
  - A good read drives array[index] onto `rdata`, registered at DONE entry.
  - Next state is always IDLE.
- Word index: addr[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- Error cases:
  - Causes: addr[1:0] ≠ 0, or `mem_read` and `mem_write` both high at acceptance.
  - The request completes normally with `err` = 1 during `mem_ready`.
  - No array write occurs; `rdata` is forced to 0; counters do not increment.
- Reset (asynchronous, mid-operation included):
  - FSM → IDLE; `mem_ready`, `err`, `busy` = 0; `rdata` = 0; counters = 0.
  - Any pending write is discarded.
  - Array contents are not reset.

## Timing

- Acceptance edge is cycle 0. `mem_ready` is high in cycle WAIT_CYCLES+1.
  - WAIT_CYCLES=0 → `mem_ready` in cycle 1.
- Back-to-back: a request held through DONE is re-accepted in the following IDLE cycle. Minimum period is WAIT_CYCLES+2 cycles.
- Read-after-write to the same address sees the new data: the write commits at DONE, before the next acceptance.
- `busy` goes high the cycle after acceptance and low in the IDLE cycle following DONE.
- `rdata` changes only at DONE entry of a read.

## Configuration

- MEM_STATS_EN defined:
  - `read_count`/`write_count` increment at each good read/write DONE.
  - Both wrap at 2^32.
- MEM_STATS_EN undefined: the counter registers are not built; `read_count` and `write_count` are tied to 0.

## Structure

- Package `mem_resp_pkg`:
  - state enum {IDLE, WAIT, DONE};
  - WORD_W = 32;
  - op encoding {OP_RD, OP_WR};
  - max-wait constant 15.
- Sub-module `mem_resp_array`:
  - DEPTH_WORDS×32 storage;
  - synchronous write enable, combinational read port.
  - Keeps the FSM independent of the storage implementation.

## Test plan

1. Reset, WAIT_CYCLES=2; write 0xDEADBEEF to addr 0x10, then read addr 0x10 → `mem_ready` in cycle 3 each time; `rdata` = 0xDEADBEEF; `err` = 0.
2. WAIT_CYCLES=0 back-to-back reads of addr 0x0 and 0x4, requests held → `mem_ready` pulses 2 cycles apart; correct data each.
3. Read addr 0x12 (misaligned), then `mem_read` and `mem_write` both high at 0x8 → `err` = 1 with each `mem_ready`; `rdata` = 0; word 0x8 unchanged; counters unchanged.
4. DEPTH_WORDS=256; write 0x5 to addr 0x400, read addr 0x0 → `rdata` = 0x5 (wrap).
5. Assert `rst` low during WAIT of a write to 0x20 → all outputs 0 immediately; word 0x20 keeps its old value; next request is served normally.
6. With MEM_STATS_EN: 3 good reads, 2 good writes, 1 misaligned access → `read_count` = 3, `write_count` = 2. Without the macro → both 0.
